dmem_mmio_ctrl: RTL

Synthesizable data-memory and test-status block that serves the `risc_v_top` data port (`RD`/`Addr`/`WD`/`WE`/`Strobe`). It replaces the bench-only word-write stub and LED-address monitor with parametrised depth, per-byte strobed writes, a readable status register and a hardware timeout. Verdict logic lives in RTL, so the same block serves simulation benches and FPGA bring-up; the bench only watches `done`/`pass`.

---
 rtl/dmem_mmio_ctrl_pkg.sv | 41 ++++
 rtl/dmem_mmio_ctrl_if.sv | 19 +
 rtl/dmem_mmio_ctrl_bytewe_ram.sv | 36 +++
 rtl/dmem_mmio_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/dmem_mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_pkg
// Brief    : Shared types and constants for the data-memory / MMIO status
//            block: FSM state encoding, MMIO register offsets, PASS code.
// Revision : 1.0  initial release
// ============================================================================
package dmem_mmio_pkg;

    // Verdict FSM encoding, also the value returned by the STATUS register
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } mmio_state_e;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0]  OFF_LED    = 4'h0;
    localparam logic [3:0]  OFF_STATUS = 4'h4;
    localparam logic [3:0]  OFF_CYCLES = 4'h8;

    // LED value that signals a passing program
    localparam logic [31:0] PASS_CODE  = 32'h0000_0001;

    // Replace the byte lanes selected by strb, keep the others from old_val
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_ctrl_if
// Brief    : Core data-port bus (address, write data, write enable, byte
//            strobes, combinational read data).
// Revision : 1.0  initial release
// ============================================================================
interface dmem_mmio_ctrl_if;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        WE;
    logic [3:0]  Strobe;
    logic [31:0] RD;

    // Core side drives the request, memory side returns read data
    modport master (output Addr, output WD, output WE, output Strobe, input  RD);
    modport slave  (input  Addr, input  WD, input  WE, input  Strobe, output RD);
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_ctrl_bytewe_ram.sv
`default_nettype none
// ============================================================================
// Module   : bytewe_ram
// Brief    : DEPTH_WORDS x 32 data RAM, combinational read, byte-lane
//            strobed synchronous write. Contents are not reset.
// Revision : 1.0  initial release
// ============================================================================
module bytewe_ram #(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] addr_i,
    input  wire logic [31:0]   wdata_i,
    input  wire logic [3:0]    strobe_i,
    output logic      [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_ctrl
// Brief    : Data RAM plus MMIO test-status window (LED, STATUS, CYCLES,
//            reserved) with in-hardware PASS/FAIL/TIMEOUT verdict FSM.
//            Optional macro DMEM_MMIO_CYCLE_CNT_EN adds a 32-bit cycle
//            counter readable at MMIO offset 0x8.
// Revision : 1.0  initial release
// ============================================================================
module dmem_mmio_ctrl
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 250
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dmem_mmio_ctrl_if.slave  bus,
    output logic      [31:0] led,
    output logic      [1:0]  state,
    output logic             done,
    output logic             pass
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned TCW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    mmio_state_e    state_q;
    logic [31:0]    led_q;
    logic [31:0]    led_d;
    logic [TCW-1:0] tcnt_q;

    logic           w_ram_hit;
    logic           w_mmio_hit;
    logic [3:0]     w_off;
    logic           w_led_we;
    logic [31:0]    w_ram_rdata;
    logic [31:0]    w_cycles;
    logic [31:0]    w_rd;
    logic           w_unused_addr;

    // Address decode: RAM takes priority should the two regions ever overlap
    assign w_ram_hit     = (bus.Addr[31:AW+2] == '0);
    assign w_mmio_hit    = (bus.Addr[31:4] == MMIO_BASE[31:4]) && !w_ram_hit;
    assign w_off         = {bus.Addr[3:2], 2'b00};
    assign w_led_we      = bus.WE && w_mmio_hit && (w_off == OFF_LED);
    assign led_d         = lane_merge(led_q, bus.WD, bus.Strobe);
    assign w_unused_addr = &{1'b0, bus.Addr[1:0]};

    bytewe_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk      (clk),
        .we_i     (bus.WE && w_ram_hit),
        .addr_i   (bus.Addr[AW+1:2]),
        .wdata_i  (bus.WD),
        .strobe_i (bus.Strobe),
        .rdata_o  (w_ram_rdata)
    );

    // Verdict FSM: first LED write decides PASS/FAIL, else timeout; terminal states stick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            led_q   <= '0;
            tcnt_q  <= '0;
        end else if (state_q == ST_RUN) begin
            tcnt_q <= tcnt_q + TCW'(1);
            if (w_led_we) begin
                led_q   <= led_d;
                state_q <= (led_d == PASS_CODE) ? ST_PASS : ST_FAIL;
            end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TCW'(TO_LAST))) begin
                state_q <= ST_TIMEOUT;
            end
        end
    end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    // Free-running cycle counter that stops once a verdict is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else if (state_q == ST_RUN) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign w_cycles = cyc_q;
`else
    assign w_cycles = '0;
`endif

    // Combinational read mux; unmapped addresses read zero
    always_comb begin
        w_rd = '0;
        if (w_ram_hit) begin
            w_rd = w_ram_rdata;
        end else if (w_mmio_hit) begin
            case (w_off)
                OFF_LED:    w_rd = led_q;
                OFF_STATUS: w_rd = {30'b0, state_q};
                OFF_CYCLES: w_rd = w_cycles;
                default:    w_rd = '0;
            endcase
        end
    end

    assign bus.RD = w_rd;
    assign led    = led_q;
    assign state  = state_q;
    assign done   = (state_q != ST_RUN);
    assign pass   = (state_q == ST_PASS);

endmodule
`default_nettype wire
